// File: rtl/ram_port_arbiter_if.sv
// ram_* handshake bundle shared by the masters' side and the bram_controller side.
// NUM_CH=1 gives the single bram_controller port; NUM_CH=N gives N packed master channels.
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 1
);
    logic [NUM_CH*DATA_WIDTH-1:0] addr;
    logic [NUM_CH-1:0]            enable;
    logic [NUM_CH-1:0]            rw;
    logic [NUM_CH-1:0]            op_size;
    logic [NUM_CH-1:0]            finishes_op;
    logic [NUM_CH*DATA_WIDTH-1:0] write;
    logic [NUM_CH-1:0]            write_req_input;
    logic [DATA_WIDTH-1:0]        read;
    logic [NUM_CH-1:0]            read_valid;
    logic [NUM_CH-1:0]            last;

    modport master (
        output addr, enable, rw, op_size, finishes_op, write,
        input  write_req_input, read, read_valid, last
    );

    modport slave (
        input  addr, enable, rw, op_size, finishes_op, write,
        output write_req_input, read, read_valid, last
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin N-master front end for the single bram_controller port,
// with abort handling and a BUSY watchdog.
module ram_port_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_MASTERS     = 4,
    parameter int MASTER_ID_WIDTH = 2,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    ram_port_arbiter_if.slave          m_bus,
    ram_port_arbiter_if.master         ram_bus,
    output logic [NUM_MASTERS-1:0]     m_grant,
    output logic                       timeout_err,
    output logic [MASTER_ID_WIDTH-1:0] timeout_id
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    localparam bit          WD_ON   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                     r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0]     r_grant, w_grant_nxt, w_win_oh;
    logic [MASTER_ID_WIDTH-1:0] r_gidx, w_gidx_nxt;
    logic [MASTER_ID_WIDTH-1:0] r_rr_ptr, w_rr_nxt;
    logic [MASTER_ID_WIDTH-1:0] r_tid, w_tid_nxt;
    logic [MASTER_ID_WIDTH-1:0] w_win, w_idx;
    logic [15:0]                r_wdog, w_wdog_nxt;
    logic                       r_terr, w_terr_nxt;
    logic                       w_any, w_busy, w_g_en, w_timeout;

    // Scan downward so the last hit is the first requester after rr_ptr.
    always_comb begin
        w_any = 1'b0;
        w_win = r_rr_ptr;
        w_idx = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_idx = MASTER_ID_WIDTH'((int'(r_rr_ptr) + k) % NUM_MASTERS);
            if (m_bus.enable[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
        w_win_oh = NUM_MASTERS'(1) << w_win;
    end

    assign w_busy    = (r_state == BUSY);
    assign w_g_en    = m_bus.enable[r_gidx];
    assign w_timeout = WD_ON && (r_wdog == WD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_rr_nxt    = r_rr_ptr;
        w_tid_nxt   = r_tid;
        w_wdog_nxt  = '0;
        w_terr_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = BUSY;
                    w_gidx_nxt  = w_win;
                    w_grant_nxt = w_win_oh;
                end
            end
            BUSY: begin
                w_wdog_nxt = r_wdog + 16'd1;
                if (ram_bus.last[0] || !w_g_en || w_timeout) begin
                    w_state_nxt = RELEASE;
                    w_grant_nxt = '0;
                    w_rr_nxt    = r_gidx;
                    // ram_last and abort both outrank the watchdog
                    if (!ram_bus.last[0] && w_g_en) begin
                        w_terr_nxt = 1'b1;
                        w_tid_nxt  = r_gidx;
                    end
                end
            end
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= MASTER_ID_WIDTH'(NUM_MASTERS - 1);
            r_tid    <= '0;
            r_wdog   <= '0;
            r_terr   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_gidx   <= w_gidx_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_tid    <= w_tid_nxt;
            r_wdog   <= w_wdog_nxt;
            r_terr   <= w_terr_nxt;
        end
    end

    always_comb begin
        ram_bus.addr        = m_bus.addr[int'(r_gidx)*DATA_WIDTH +: DATA_WIDTH];
        ram_bus.write       = m_bus.write[int'(r_gidx)*DATA_WIDTH +: DATA_WIDTH];
        ram_bus.rw          = m_bus.rw[r_gidx];
        ram_bus.op_size     = m_bus.op_size[r_gidx];
        ram_bus.finishes_op = m_bus.finishes_op[r_gidx];
        ram_bus.enable      = w_busy & w_g_en;
    end

    // r_grant is one-hot on the granted index exactly while BUSY
    assign m_bus.read            = ram_bus.read;
    assign m_bus.write_req_input = {NUM_MASTERS{w_busy & ram_bus.write_req_input[0]}} & r_grant;
    assign m_bus.read_valid      = {NUM_MASTERS{w_busy & ram_bus.read_valid[0]}} & r_grant;
    assign m_bus.last            = {NUM_MASTERS{w_busy & ram_bus.last[0]}} & r_grant;
    assign m_grant               = r_grant;
    assign timeout_err           = r_terr;
    assign timeout_id            = r_tid;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: vector table, directed corner sequences,
// and a randomized run against a transaction-level round-robin model.
module tb_ram_port_arbiter;
    localparam int DW = 32;
    localparam int NM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NM-1:0] grant;
    logic          terr;
    logic [1:0]    tid;
    int            n_chk = 0;
    int            n_fail = 0;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .NUM_CH(NM)) m_if ();
    ram_port_arbiter_if #(.DATA_WIDTH(DW), .NUM_CH(1))  r_if ();

    ram_port_arbiter #(
        .DATA_WIDTH(DW), .NUM_MASTERS(NM),
        .MASTER_ID_WIDTH(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .m_bus(m_if), .ram_bus(r_if),
        .m_grant(grant), .timeout_err(terr), .timeout_id(tid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic        rw;
        logic        op;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  exp_grant;
    } vec_t;

    vec_t vecs[4];

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr();
        m_if.addr = '0; m_if.enable = '0; m_if.rw = '0;
        m_if.op_size = '0; m_if.finishes_op = '0; m_if.write = '0;
        r_if.write_req_input = '0; r_if.read = '0;
        r_if.read_valid = '0; r_if.last = '0;
    endtask

    task automatic set_m(input int i, input logic en, input logic [31:0] a,
                         input logic rw, input logic op, input logic [31:0] wd);
        m_if.enable[i] = en;
        m_if.addr[i*DW +: DW] = a;
        m_if.rw[i] = rw;
        m_if.op_size[i] = op;
        m_if.finishes_op[i] = 1'b0;
        m_if.write[i*DW +: DW] = wd;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_ram_en", r_if.enable, 0);
        chk("rst_terr", terr, 0);
        chk("rst_tid", tid, 0);
        chk("rst_m_last", m_if.last, 0);
        chk("rst_m_rv", m_if.read_valid, 0);
        chk("rst_m_wri", m_if.write_req_input, 0);
    endtask

    task automatic wait_grant(input logic [3:0] exp, input int maxc,
                              input string nm, output int took);
        took = 0;
        for (int c = 0; c < maxc; c++) begin
            cyc();
            #1;
            took++;
            if (grant != 0) break;
        end
        chk(nm, grant, exp);
    endtask

    task automatic finish_txn(input int idx, input bit keep);
        logic [3:0] oh;
        oh = 4'b1 << idx;
        r_if.last = 1'b1;
        r_if.read_valid = 1'b1;
        #1;
        chk("fin_m_last", m_if.last, oh);
        cyc();
        r_if.last = 1'b0;
        r_if.read_valid = 1'b0;
        if (!keep) m_if.enable[idx] = 1'b0;
        #1;
        chk("rel_grant", grant, 0);
        chk("rel_ram_en", r_if.enable, 0);
    endtask

    initial begin
        int took, pulses;
        int order[6];
        logic [3:0] oh;
        logic [3:0] prev_en, gprev, gprev2, mlast_obs, g, exp_oh;
        int last_g, target, cnt, exp_i, maxw;
        int wc[4];
        bit ren_obs, last_prev, last_drv, wri_drv, found;

        vecs[0] = '{2, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'hCAFE_0100, 4'b0100};
        vecs[1] = '{0, 32'h0000_0A04, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 4'b0001};
        vecs[2] = '{3, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'b1000};
        vecs[3] = '{1, 32'h8000_0000, 1'b1, 1'b1, 32'hA5A5_5A5A, 32'h0, 4'b0010};

        do_reset();

        for (int v = 0; v < 4; v++) begin
            set_m(vecs[v].idx, 1'b1, vecs[v].addr, vecs[v].rw, vecs[v].op, vecs[v].wdata);
            wait_grant(vecs[v].exp_grant, 1, "tbl_grant", took);
            chk("tbl_ram_en", r_if.enable, 1);
            chk("tbl_addr", r_if.addr, vecs[v].addr);
            chk("tbl_rw", r_if.rw, vecs[v].rw);
            chk("tbl_op", r_if.op_size, vecs[v].op);
            chk("tbl_wdata", r_if.write, vecs[v].wdata);
            r_if.read = vecs[v].rdata;
            r_if.read_valid = 1'b1;
            #1;
            chk("tbl_rv", m_if.read_valid, vecs[v].exp_grant);
            chk("tbl_rdata", m_if.read, vecs[v].rdata);
            finish_txn(vecs[v].idx, 1'b0);
            cyc();
            #1;
            chk("tbl_idle_grant", grant, 0);
        end

        // masters 0 and 3 together after reset
        do_reset();
        set_m(0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
        set_m(3, 1'b1, 32'h30, 1'b0, 1'b0, 32'h0);
        wait_grant(4'b0001, 1, "rr03_first", took);
        finish_txn(0, 1'b0);
        wait_grant(4'b1000, 2, "rr03_second", took);
        chk("rr03_gap", took, 2);
        finish_txn(3, 1'b0);

        // masters 0, 1, 3 requesting continuously
        do_reset();
        set_m(0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
        set_m(1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0);
        set_m(3, 1'b1, 32'h1C, 1'b0, 1'b0, 32'h0);
        order = '{0, 1, 3, 0, 1, 3};
        for (int k = 0; k < 6; k++) begin
            oh = 4'b1 << order[k];
            wait_grant(oh, 2, "rr_cont", took);
            if (k > 0) chk("rr_cont_gap", took, 2);
            finish_txn(order[k], 1'b1);
        end
        clr();

        // 8-beat burst write with a competing request
        do_reset();
        set_m(1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h0);
        wait_grant(4'b0010, 1, "burst_grant", took);
        set_m(0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
        pulses = 0;
        for (int b = 0; b < 8; b++) begin
            r_if.write_req_input = 1'b1;
            m_if.write[DW +: DW] = 32'hB000_0000 + 32'(b);
            m_if.finishes_op[1] = (b == 7);
            #1;
            if (m_if.write_req_input[1]) pulses++;
            chk("burst_wri", m_if.write_req_input, 4'b0010);
            chk("burst_wdata", r_if.write, 32'hB000_0000 + 32'(b));
            chk("burst_fin", r_if.finishes_op, (b == 7));
            chk("burst_hold", grant, 4'b0010);
            cyc();
        end
        r_if.write_req_input = 1'b0;
        chk("burst_pulses", pulses, 8);
        finish_txn(1, 1'b0);
        wait_grant(4'b0001, 2, "burst_next", took);
        finish_txn(0, 1'b0);

        // abort after three BUSY cycles
        do_reset();
        set_m(0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        set_m(1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0);
        wait_grant(4'b0001, 1, "abort_grant", took);
        repeat (3) cyc();
        m_if.enable[0] = 1'b0;
        #1;
        chk("abort_ram_en", r_if.enable, 0);
        chk("abort_no_last", m_if.last, 0);
        cyc();
        #1;
        chk("abort_rel_grant", grant, 0);
        chk("abort_rel_last", m_if.last, 0);
        wait_grant(4'b0010, 2, "abort_next", took);
        finish_txn(1, 1'b0);

        // watchdog fires after 16 BUSY cycles
        do_reset();
        set_m(2, 1'b1, 32'h50, 1'b0, 1'b0, 32'h0);
        set_m(3, 1'b1, 32'h54, 1'b0, 1'b0, 32'h0);
        wait_grant(4'b0100, 1, "to_grant", took);
        for (int c = 1; c <= 16; c++) begin
            chk("to_no_err", terr, 0);
            chk("to_hold", grant, 4'b0100);
            cyc();
            #1;
        end
        chk("to_err", terr, 1);
        chk("to_id", tid, 2);
        chk("to_rel_grant", grant, 0);
        cyc();
        #1;
        chk("to_pulse_end", terr, 0);
        chk("to_id_held", tid, 2);
        wait_grant(4'b1000, 1, "to_next", took);
        finish_txn(3, 1'b0);
        m_if.enable[2] = 1'b0;

        // ram_last on the 16th cycle beats the watchdog
        do_reset();
        set_m(1, 1'b1, 32'h60, 1'b0, 1'b0, 32'h0);
        wait_grant(4'b0010, 1, "tol_grant", took);
        repeat (15) begin
            cyc();
            #1;
        end
        finish_txn(1, 1'b0);
        chk("tol_no_err", terr, 0);
        chk("tol_id", tid, 0);

        // asynchronous reset in mid-burst
        do_reset();
        set_m(1, 1'b1, 32'h70, 1'b1, 1'b1, 32'h0);
        wait_grant(4'b0010, 1, "rstb_grant", took);
        r_if.write_req_input = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("rstb_ram_en", r_if.enable, 0);
        chk("rstb_grant0", grant, 0);
        chk("rstb_wri", m_if.write_req_input, 0);
        cyc();
        rst = 1'b0;
        r_if.write_req_input = 1'b0;
        set_m(0, 1'b1, 32'h74, 1'b0, 1'b0, 32'h0);
        wait_grant(4'b0001, 1, "rstb_first", took);
        finish_txn(0, 1'b0);

        // randomized traffic against a round-robin transaction model
        do_reset();
        last_g = NM - 1;
        prev_en = '0; gprev = '0; gprev2 = '0; mlast_obs = '0;
        ren_obs = 1'b0; last_prev = 1'b0; cnt = 0;
        target = $urandom_range(1, 6);
        for (int j = 0; j < NM; j++) wc[j] = 0;
        for (int it = 0; it < 1500; it++) begin
            cyc();
            for (int i = 0; i < NM; i++) begin
                if (mlast_obs[i]) m_if.enable[i] = 1'b0;
                else if (!m_if.enable[i] && $urandom_range(3) == 0)
                    set_m(i, 1'b1, $urandom, 1'($urandom_range(1)),
                          1'($urandom_range(1)), $urandom);
            end
            last_drv = 1'b0;
            if (ren_obs && !last_prev) begin
                cnt++;
                if (cnt >= target) begin
                    last_drv = 1'b1;
                    cnt = 0;
                    target = $urandom_range(1, 6);
                end
            end
            wri_drv = 1'($urandom_range(1));
            r_if.last = last_drv;
            r_if.read_valid = last_drv;
            r_if.write_req_input = wri_drv;
            r_if.read = $urandom;
            #1;
            g = grant;
            chk("rnd_bcast", m_if.read, r_if.read);
            if (g != 0 && gprev == 0) begin
                found = 1'b0;
                exp_i = last_g;
                for (int k = NM; k >= 1; k--)
                    if (prev_en[(last_g + k) % NM]) begin
                        found = 1'b1;
                        exp_i = (last_g + k) % NM;
                    end
                chk("rnd_req_seen", found, 1);
                exp_oh = 4'b1 << exp_i;
                chk("rnd_rr_order", g, exp_oh);
                for (int j = 0; j < NM; j++)
                    if (j != exp_i && prev_en[j]) wc[j]++;
                wc[exp_i] = 0;
                maxw = 0;
                for (int j = 0; j < NM; j++) if (wc[j] > maxw) maxw = wc[j];
                chk("rnd_starve", (maxw > NM - 1), 0);
                last_g = exp_i;
            end
            if (g != 0 && gprev != 0) chk("rnd_hold", g, gprev);
            if (g == 0 && gprev == 0 && gprev2 == 0) chk("rnd_idle_arb", prev_en, 0);
            if (g != 0) begin
                chk("rnd_onehot", $onehot(g), 1);
                chk("rnd_addr", r_if.addr, m_if.addr[last_g*DW +: DW]);
                chk("rnd_ram_en", r_if.enable, 1);
                chk("rnd_m_last", m_if.last, last_drv ? g : 4'b0);
                chk("rnd_wri", m_if.write_req_input, wri_drv ? g : 4'b0);
            end else begin
                chk("rnd_idle_en", r_if.enable, 0);
                chk("rnd_idle_last", m_if.last, 0);
            end
            gprev2 = gprev;
            gprev = g;
            prev_en = m_if.enable;
            mlast_obs = m_if.last;
            ren_obs = r_if.enable[0];
            last_prev = last_drv;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Parametrised N-master front end for the single bram_controller port; lets mips_cpu, the UART loader and future DMA share RAM, which is currently hard-wired to one master.
- Sits between the masters and bram_controller and uses the same ram_* handshake on both sides.
- Round-robin grant, held for a whole transaction (including bursts).
- Adds abort and watchdog-timeout recovery, which the direct connection lacks.

Parameters:
DATA_WIDTH, 32, address/data width of every port
NUM_MASTERS, 4, number of master channels (2..16)
MASTER_ID_WIDTH, 2, width of the grant index; must satisfy 2^MASTER_ID_WIDTH >= NUM_MASTERS
TIMEOUT_CYCLES, 1023, BUSY cycles allowed without ram_last; 0 disables the watchdog; must be < 65536

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
m_addr  in  NUM_MASTERS*DATA_WIDTH  per-master address; master i in slice [i*DATA_WIDTH +: DATA_WIDTH]
m_enable  in  NUM_MASTERS  request; held high by the master until its m_last
m_rw  in  NUM_MASTERS  1=write, 0=read
m_op_size  in  NUM_MASTERS  0=single word, 1=burst
m_finishes_op  in  NUM_MASTERS  master marks the final burst beat
m_write  in  NUM_MASTERS*DATA_WIDTH  per-master write data
m_write_req_input  out  NUM_MASTERS  write-data request, routed to the granted master only
m_read  out  DATA_WIDTH  read data, broadcast to all masters
m_read_valid  out  NUM_MASTERS  read-valid, routed to the granted master only
m_last  out  NUM_MASTERS  transaction done, routed to the granted master only
m_grant  out  NUM_MASTERS  one-hot grant, registered
ram_addr  out  DATA_WIDTH  to bram_controller
ram_enable  out  1  to bram_controller
ram_rw  out  1  to bram_controller
ram_op_size  out  1  to bram_controller
ram_finishes_op  out  1  to bram_controller
ram_write  out  DATA_WIDTH  to bram_controller
ram_write_req_input  in  1  from bram_controller
ram_read  in  DATA_WIDTH  from bram_controller
ram_read_valid  in  1  from bram_controller
ram_last  in  1  from bram_controller
timeout_err  out  1  one-cycle pulse when the watchdog fires
timeout_id  out  MASTER_ID_WIDTH  index of the master that timed out; held until the next timeout

Behaviour:
- Reset (async, rst=1) gives:
  - state=IDLE, m_grant=0, rr_ptr=NUM_MASTERS-1, watchdog=0
  - timeout_err=0, timeout_id=0, ram_enable=0
  - m_last, m_read_valid and m_write_req_input all 0
- State IDLE:
  - ram_enable=0.
  - If any m_enable is high, grant the first requester scanning from rr_ptr+1 upward, wrapping modulo NUM_MASTERS.
  - Grant register loads on this edge and state goes to BUSY.
  - Latency: request at edge t → m_grant and ram_enable high after edge t+1.
- State BUSY, granted index g:
  - ram_addr/rw/op_size/finishes_op/write are combinationally muxed from master g; ram_enable = m_enable[g].
  - ram_write_req_input, ram_read_valid and ram_last are forwarded combinationally to bit g of the matching m_* output; all other bits are 0.
  - m_read = ram_read at all times.
  - Watchdog counts +1 per BUSY cycle.
- BUSY exits, in priority order:
  1. ram_last=1 → RELEASE, rr_ptr=g (normal completion).
  2. m_enable[g]=0 before ram_last (abort) → RELEASE, rr_ptr=g, no m_last generated.
  3. TIMEOUT_CYCLES≠0 and watchdog==TIMEOUT_CYCLES-1 with no ram_last → RELEASE, timeout_err pulses for one cycle, timeout_id=g, rr_ptr=g.
  - If ram_last and the timeout coincide, ram_last wins and there is no error.
- State RELEASE:
  - ram_enable=0 and m_grant=0 for exactly one cycle, so bram_controller sees enable deassert between transactions.
  - Watchdog clears; go to IDLE.
- Minimum spacing between consecutive transactions is therefore 2 idle cycles (RELEASE + IDLE arbitration).
- Requests from non-granted masters are ignored while BUSY; they stay pending because masters hold m_enable.
- A master dropping its request while not granted has no effect.
- Fairness: with all masters requesting continuously, grants cycle 0,1,...,N-1,0,...; no master waits longer than N-1 transactions.
- Reset mid-transaction: everything returns to reset values immediately. ram_enable drops asynchronously, so bram_controller (reset by the same source) aborts too.

Test Plan:
- Single read: only master 2 requests addr 0x100, rw=0, op_size=0 → m_grant=4'b0100 one cycle later; ram_addr=0x100; master 2 sees m_read_valid and m_last, others stay 0; RELEASE then IDLE.
- Round-robin: masters 0 and 3 request at the same cycle after reset → grant order 0, 3. Masters 0, 1 and 3 requesting continuously → order 0, 1, 3, 0, 1, 3, each separated by the enable-low RELEASE cycle.
- Burst write: master 1, op_size=1, 8 beats, finishes_op on beat 8 → 8 m_write_req_input[1] pulses; m_grant holds for the whole burst; master 0's simultaneous request is served only after m_last[1].
- Abort: master 0 drops m_enable after 3 BUSY cycles without ram_last → ram_enable=0 the next cycle, no m_last[0], master 1 granted next.
- Timeout: TIMEOUT_CYCLES=16, slave never raises ram_last → timeout_err pulses after 16 BUSY cycles with timeout_id=g, then grant advances. Repeat with ram_last on cycle 16 → no error.
- Reset in BUSY mid-burst: rst high → ram_enable and m_grant drop without waiting for a clock edge; after release the first grant goes to master 0.
